// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq_ctrl
// Purpose  : Top-level sequencer for the serial signed multiplier. Each
//            accepted start shifts the operands in, launches the core, waits
//            for its result (bounded by a timeout), streams the product out
//            and verifies the shiftout finished flag before pulsing done.
// Ports    : Clk      - system clock, rising edge
//            reset_n  - asynchronous active-low reset
//            start    - transaction request (sampled only when idle)
//            abort    - synchronous abort, honoured in every busy state
//            mult_rdy - multiplier core result valid
//            Fx       - shiftout finished flag (sticky)
//            busy     - high whenever not idle
//            done     - one-cycle completion pulse
//            err      - sticky error, cleared when the next start is accepted
//            ld_en    - operand shift-in enable
//            mult_go  - one-cycle multiplier launch strobe
//            Sx       - shiftout enable
//            bit_idx  - current bit during operand load / product shift
// Revision : 1.0 - initial release
// ============================================================================
module mult_seq_ctrl #(
  parameter int IN_WIDTH      = 8,
  parameter int OUT_WIDTH     = 16,
  parameter int COUNTER_WIDTH = 5,
  parameter int MULT_TIMEOUT  = 64,
  parameter int TMO_WIDTH     = 7
) (
  input  logic                     Clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     mult_rdy,
  input  logic                     Fx,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     ld_en,
  output logic                     mult_go,
  output logic                     Sx,
  output logic [COUNTER_WIDTH-1:0] bit_idx
);

  localparam logic [COUNTER_WIDTH-1:0] IN_LAST  = COUNTER_WIDTH'(IN_WIDTH - 1);
  localparam logic [COUNTER_WIDTH-1:0] OUT_LAST = COUNTER_WIDTH'(OUT_WIDTH - 1);
  localparam logic [TMO_WIDTH-1:0]     TMO_LAST = TMO_WIDTH'(MULT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MULT  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_SHIFT = 3'd4,
    ST_CHECK = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [TMO_WIDTH-1:0]     tmo_q, tmo_d;
  logic                     err_q, err_d;

  // Output flops: next values are decoded from the next state so every
  // output is a plain register with no path from the inputs.
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     ld_en_q, ld_en_d;
  logic                     mult_go_q, mult_go_d;
  logic                     sx_q, sx_d;
  logic [COUNTER_WIDTH-1:0] bit_idx_q, bit_idx_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        tmo_d = '0;
        if (start && !abort) begin
          state_d = ST_LOAD;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (cnt_q == IN_LAST) begin
          state_d = ST_MULT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + COUNTER_WIDTH'(1);
        end
      end
      ST_MULT: begin
        state_d = ST_WAIT;
        tmo_d   = '0;
      end
      ST_WAIT: begin
        if (mult_rdy) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          // Core never answered: report it and skip the product shift.
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_WIDTH'(1);
        end
      end
      ST_SHIFT: begin
        if (cnt_q == OUT_LAST) begin
          state_d = ST_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + COUNTER_WIDTH'(1);
        end
      end
      ST_CHECK: begin
        if (!Fx) begin
          err_d = 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tmo_d   = '0;
      end
    endcase

    // Abort overrides whatever the state decided, including a pending
    // error update, so err keeps its previous value.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      tmo_d   = '0;
      err_d   = err_q;
    end

    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    ld_en_d   = (state_d == ST_LOAD);
    mult_go_d = (state_d == ST_MULT);
    sx_d      = (state_d == ST_SHIFT);
    bit_idx_d = ((state_d == ST_LOAD) || (state_d == ST_SHIFT)) ? cnt_d : '0;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ld_en_q   <= 1'b0;
      mult_go_q <= 1'b0;
      sx_q      <= 1'b0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ld_en_q   <= ld_en_d;
      mult_go_q <= mult_go_d;
      sx_q      <= sx_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign ld_en   = ld_en_q;
  assign mult_go = mult_go_q;
  assign Sx      = sx_q;
  assign bit_idx = bit_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_seq_ctrl
// Purpose  : Self-checking bench for mult_seq_ctrl. Each transaction's
//            expected output trace is built from the protocol description
//            (phase lengths and strobes) and compared cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_seq_ctrl;

  localparam int IW  = 8;
  localparam int OW  = 16;
  localparam int CW  = 5;
  localparam int TMO = 64;

  logic          Clk      = 1'b0;
  logic          reset_n  = 1'b0;
  logic          start    = 1'b0;
  logic          abort    = 1'b0;
  logic          mult_rdy = 1'b0;
  logic          Fx       = 1'b0;
  logic          busy, done, err, ld_en, mult_go, Sx;
  logic [CW-1:0] bit_idx;

  int   n_total   = 0;
  int   n_bad     = 0;
  logic model_err = 1'b0;

  mult_seq_ctrl #(
    .IN_WIDTH     (IW),
    .OUT_WIDTH    (OW),
    .COUNTER_WIDTH(CW),
    .MULT_TIMEOUT (TMO),
    .TMO_WIDTH    (7)
  ) dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .start   (start),
    .abort   (abort),
    .mult_rdy(mult_rdy),
    .Fx      (Fx),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .ld_en   (ld_en),
    .mult_go (mult_go),
    .Sx      (Sx),
    .bit_idx (bit_idx)
  );

  always #5 Clk = ~Clk;

  // Output vector layout: {busy, done, err, ld_en, mult_go, Sx, bit_idx}
  function automatic logic [10:0] vec(input bit b, input bit d, input bit e,
                                      input bit l, input bit g, input bit s,
                                      input int idx);
    return {b, d, e, l, g, s, 5'(idx)};
  endfunction

  function automatic logic [10:0] obs();
    return {busy, done, err, ld_en, mult_go, Sx, bit_idx};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Runs one transaction starting from an idle negedge. w = WAIT cycles
  // (ignored when tmo), abort_at / rst_at = trace index to abort or reset
  // at (-1 for none), hold keeps start high throughout.
  task automatic do_txn(input int w, input bit tmo, input bit fx,
                        input int abort_at, input int rst_at, input bit hold);
    logic [10:0] q[$];
    bit          e;
    int          wait_n;
    int          check_idx;
    wait_n    = tmo ? TMO : w;
    e         = tmo || !fx;
    check_idx = IW + 1 + wait_n + OW;
    for (int i = 0; i < IW; i++) q.push_back(vec(1, 0, 0, 1, 0, 0, i));
    q.push_back(vec(1, 0, 0, 0, 1, 0, 0));
    repeat (wait_n) q.push_back(vec(1, 0, 0, 0, 0, 0, 0));
    if (!tmo) begin
      for (int i = 0; i < OW; i++) q.push_back(vec(1, 0, 0, 0, 0, 1, i));
      q.push_back(vec(1, 0, 0, 0, 0, 0, 0));
    end
    q.push_back(vec(1, 1, e, 0, 0, 0, 0));

    chk("idle_pre", obs(), vec(0, 0, model_err, 0, 0, 0, 0));
    start    = 1'b1;
    abort    = 1'b0;
    mult_rdy = 1'b0;
    @(negedge Clk);
    for (int j = 0; j < q.size(); j++) begin
      chk($sformatf("trace[%0d]", j), obs(), q[j]);
      start = hold ? 1'b1 : 1'($urandom % 2);
      if (!tmo && j == IW + w)
        mult_rdy = 1'b1;
      else if (j >= IW + 1 && j <= IW + wait_n)
        mult_rdy = 1'b0;
      else
        mult_rdy = 1'($urandom % 2);
      Fx    = (!tmo && j == check_idx) ? fx : 1'($urandom % 2);
      abort = (j == abort_at);
      if (j == rst_at) begin
        #1 reset_n = 1'b0;
        #1 chk("rst_async", obs(), 32'd0);
        model_err = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        @(negedge Clk);
        chk("rst_hold", obs(), 32'd0);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge Clk);
          chk("post_rst_idle", obs(), 32'd0);
        end
        return;
      end
      @(negedge Clk);
      if (j == abort_at) begin
        abort = 1'b0;
        chk("abort_idle", obs(), vec(0, 0, 0, 0, 0, 0, 0));
        model_err = 1'b0;
        return;
      end
    end
    abort     = 1'b0;
    model_err = e;
    chk("idle_post", obs(), vec(0, 0, model_err, 0, 0, 0, 0));
  endtask

  initial begin
    int w;
    int ab;
    bit tm;
    repeat (2) @(negedge Clk);
    chk("reset_state", obs(), 32'd0);
    reset_n = 1'b1;
    @(negedge Clk);
    chk("idle_after_reset", obs(), 32'd0);

    // Nominal transaction, W=3, Fx good
    do_txn(3, 1'b0, 1'b1, -1, -1, 1'b0);
    // Core timeout: 64 WAIT cycles, no shift, err at done
    do_txn(0, 1'b1, 1'b1, -1, -1, 1'b0);
    // Fx missing, W=1: full shift then err
    do_txn(1, 1'b0, 1'b0, -1, -1, 1'b0);
    // Abort at bit 5 of SHIFT, then a clean run clears err
    do_txn(2, 1'b0, 1'b1, IW + 1 + 2 + 5, -1, 1'b0);
    do_txn(2, 1'b0, 1'b1, -1, -1, 1'b0);

    // Abort beats a simultaneous start while idle
    start = 1'b1;
    abort = 1'b1;
    @(negedge Clk);
    chk("abort_wins_idle", obs(), vec(0, 0, model_err, 0, 0, 0, 0));
    start = 1'b0;
    abort = 1'b0;
    @(negedge Clk);

    // Reset asserted mid-SHIFT
    do_txn(2, 1'b0, 1'b1, -1, IW + 1 + 2 + 4, 1'b0);

    // Start held high: three back-to-back transactions, one idle cycle apart
    for (int n = 0; n < 3; n++) do_txn(int'($urandom_range(1, 6)), 1'b0, 1'b1, -1, -1, 1'b1);
    start = 1'b0;
    @(negedge Clk);
    chk("idle_after_hold", obs(), vec(0, 0, model_err, 0, 0, 0, 0));

    // Randomized transactions
    for (int n = 0; n < 25; n++) begin
      w  = int'($urandom_range(1, 12));
      tm = ($urandom % 8) == 0;
      ab = (($urandom % 5) == 0) ? int'($urandom_range(0, IW + 1 + OW)) : -1;
      do_txn(w, tm, ($urandom % 4) != 0, ab, -1, 1'($urandom % 2));
      if (($urandom % 3) == 0) begin
        start = 1'b0;
        repeat (int'($urandom_range(1, 3))) begin
          @(negedge Clk);
          chk("idle_gap", obs(), vec(0, 0, model_err, 0, 0, 0, 0));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
